// File: rtl/turn_sequencer_if.sv
// Signal bundle between the turn sequencer and its surroundings.
// The game side (master) drives btn/match/W; the sequencer (slave) drives the rest.
interface turn_sequencer_if;
    logic       btn;
    logic       match;
    logic       W;
    logic [1:0] T;
    logic       B;
    logic       turn_change;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_dbg;

    modport master (
        output btn,
        output match,
        output W,
        input  T,
        input  B,
        input  turn_change,
        input  game_over,
        input  winner,
        input  state_dbg
    );

    modport slave (
        input  btn,
        input  match,
        input  W,
        output T,
        output B,
        output turn_change,
        output game_over,
        output winner,
        output state_dbg
    );
endinterface

// File: rtl/turn_sequencer.sv
// Game-flow controller: debounces the player button, tracks whose turn it is,
// strobes the win-check stage and freezes the game once a winner is reported.
module turn_sequencer #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter int          NUM_PLAYERS     = 4
) (
    input  logic              clk,
    input  logic              rst,
    turn_sequencer_if.slave   bus
);

    localparam logic [19:0] DB_LAST = DEBOUNCE_CYCLES - 20'd1;
    localparam logic [1:0]  T_LAST  = 2'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        EVAL  = 3'd2,
        ADV   = 3'd3,
        CHECK = 3'd4,
        PASS  = 3'd5,
        OVER  = 3'd6
    } state_t;

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic [19:0] cnt_q, cnt_d;
    logic        press_q, press_d;

    state_t      state_q, state_d;
    logic [1:0]  t_q, t_d;
    logic [1:0]  winner_q, winner_d;
    logic        match_q, match_d;
    logic        b_q, tc_q, go_q;

    // Button path: counter runs only while the synchronized level disagrees
    // with the accepted one; DEBOUNCE_CYCLES disagreeing cycles flip it.
    always_comb begin
        level_d = level_q;
        cnt_d   = 20'd0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 20'd0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Presses in the transient states fall through untouched and are lost.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        winner_d = winner_q;
        match_d  = match_q;
        case (state_q)
            IDLE: begin
                if (press_q) state_d = PICK;
            end
            PICK: begin
                if (press_q) begin
                    match_d = bus.match;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                state_d = match_q ? ADV : PASS;
            end
            ADV: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (bus.W) begin
                    winner_d = t_q;
                    state_d  = OVER;
                end else begin
                    state_d = PICK;
                end
            end
            PASS: begin
                t_d     = (t_q == T_LAST) ? 2'd0 : t_q + 2'd1;
                state_d = PICK;
            end
            OVER: begin
                if (press_q) begin
                    t_d      = 2'd0;
                    winner_d = 2'd0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they coincide with the state they flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= 2'd0;
            winner_q <= 2'd0;
            match_q  <= 1'b0;
            b_q      <= 1'b0;
            tc_q     <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            winner_q <= winner_d;
            match_q  <= match_d;
            b_q      <= (state_d == ADV);
            tc_q     <= (state_d == PASS);
            go_q     <= (state_d == OVER);
        end
    end

    assign bus.T           = t_q;
    assign bus.B           = b_q;
    assign bus.turn_change = tc_q;
    assign bus.game_over   = go_q;
    assign bus.winner      = winner_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: one button press per table row, expected results queued
// when the press is driven and compared once the move has settled.
module tb_turn_sequencer;

    localparam logic [19:0] DB = 20'd4;
    localparam int          HOLD = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turn_sequencer_if bus ();

    turn_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .NUM_PLAYERS     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       match;
        logic       w;
        logic [1:0] t;
        int         nb;
        int         ntc;
        logic       go;
        logic [1:0] win;
        logic [2:0] st;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int b_total   = 0;
    int tc_total  = 0;
    int both_high = 0;
    int b_late    = 0;
    logic [2:0] prev_st = 3'd0;

    vec_t exp_q[$];

    always @(negedge clk) begin
        if (bus.B) b_total <= b_total + 1;
        if (bus.turn_change) tc_total <= tc_total + 1;
        if (bus.B && bus.turn_change) both_high <= both_high + 1;
        if (bus.B && prev_st != 3'd2) b_late <= b_late + 1;
        prev_st <= bus.state_dbg;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_press(input int idx, input vec_t v);
        int   b0, tc0;
        vec_t e;
        b0  = b_total;
        tc0 = tc_total;
        bus.match = v.match;
        bus.W     = v.w;
        exp_q.push_back(v);
        bus.btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        bus.btn = 1'b0;
        repeat (HOLD) @(negedge clk);
        #1;
        bus.W = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("v%0d_T", idx), int'(bus.T), int'(e.t));
        chk($sformatf("v%0d_Bcycles", idx), b_total - b0, e.nb);
        chk($sformatf("v%0d_tc", idx), tc_total - tc0, e.ntc);
        chk($sformatf("v%0d_game_over", idx), int'(bus.game_over), int'(e.go));
        chk($sformatf("v%0d_winner", idx), int'(bus.winner), int'(e.win));
        chk($sformatf("v%0d_state", idx), int'(bus.state_dbg), int'(e.st));
        $display("press %0d match=%0b W=%0b -> T=%0d B=%0d tc=%0d go=%0b win=%0d st=%0d",
                 idx, v.match, v.w, bus.T, b_total - b0, tc_total - tc0,
                 bus.game_over, bus.winner, bus.state_dbg);
    endtask

    vec_t vecs[14];

    initial begin
        int found;
        //          match  W     T     nb ntc go    win   st
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 2'd0, 3'd1}; // IDLE -> PICK
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 0, 1, 1'b0, 2'd0, 3'd1}; // miss
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 0, 1, 1'b0, 2'd0, 3'd1};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 1, 0, 1'b0, 2'd0, 3'd1}; // hit, no win
        vecs[4]  = '{1'b0, 1'b0, 2'd3, 0, 1, 1'b0, 2'd0, 3'd1};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 0, 1, 1'b0, 2'd0, 3'd1}; // wrap 3 -> 0
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 0, 1, 1'b0, 2'd0, 3'd1}; // W outside CHECK ignored
        vecs[7]  = '{1'b1, 1'b1, 2'd1, 1, 0, 1'b1, 2'd1, 3'd6}; // win by player 1
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 0, 0, 1'b0, 2'd0, 3'd0}; // OVER -> IDLE, no B
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 2'd0, 3'd1};
        vecs[10] = '{1'b0, 1'b0, 2'd1, 0, 1, 1'b0, 2'd0, 3'd1}; // four misses: 1,2,3,0
        vecs[11] = '{1'b0, 1'b0, 2'd2, 0, 1, 1'b0, 2'd0, 3'd1};
        vecs[12] = '{1'b0, 1'b0, 2'd3, 0, 1, 1'b0, 2'd0, 3'd1};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 0, 1, 1'b0, 2'd0, 3'd1};

        bus.btn = 1'b0;
        bus.match = 1'b0;
        bus.W = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_T", int'(bus.T), 0);
        chk("reset_B", int'(bus.B), 0);
        chk("reset_tc", int'(bus.turn_change), 0);
        chk("reset_game_over", int'(bus.game_over), 0);
        chk("reset_winner", int'(bus.winner), 0);
        chk("reset_state", int'(bus.state_dbg), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Glitch shorter than the debounce window must not register.
        bus.btn = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn = 1'b0;
        repeat (HOLD) @(negedge clk);
        #1;
        chk("glitch_state", int'(bus.state_dbg), 0);
        chk("glitch_T", int'(bus.T), 0);
        $display("glitch: st=%0d T=%0d", bus.state_dbg, bus.T);

        for (int i = 0; i < 14; i++) do_press(i, vecs[i]);

        chk("B_tc_overlap", both_high, 0);
        chk("B_not_after_EVAL", b_late, 0);

        // Async reset in the middle of a hit move.
        bus.match = 1'b1;
        bus.btn = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (bus.state_dbg == 3'd3) found = 1;
        end
        chk("reach_ADV", found, 1);
        if (found == 1) begin
            chk("ADV_B_high", int'(bus.B), 1);
            #1 rst = 1'b1;
            #1;
            chk("async_B", int'(bus.B), 0);
            chk("async_T", int'(bus.T), 0);
            chk("async_tc", int'(bus.turn_change), 0);
            chk("async_game_over", int'(bus.game_over), 0);
            chk("async_winner", int'(bus.winner), 0);
            chk("async_state", int'(bus.state_dbg), 0);
            $display("async reset in ADV: B=%0b st=%0d", bus.B, bus.state_dbg);
        end else begin
            rst = 1'b1;
        end
        bus.btn = 1'b0;
        bus.match = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_state", int'(bus.state_dbg), 0);
        chk("post_reset_B", int'(bus.B), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
